i2c_cmd_master: RTL and testbench

I2C_CMD_MASTER -- requirements
Module: i2c_cmd_master

---
 rtl/i2c_cmd_master.sv | 174 +++++++++++++++++
 tb/tb_i2c_cmd_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_master.sv
// Single-command I2C master: START, address byte, one write or read byte, STOP.
// A quarter-period tick engine paces every bus phase; a valid/ready host port issues commands.
module i2c_cmd_master #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [6:0] cmd_addr_i,
  input  logic       cmd_rw_i,
  input  logic [7:0] cmd_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       rsp_nack_o,
  output logic       scl_o,
  output logic       scl_oe_o,
  output logic       sda_o,
  output logic       sda_oe_o,
  input  logic       sda_i
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ADDR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       qtr_q;
  logic [2:0]       bit_q;
  logic             nack_q;

  logic [6:0]       addr_q;
  logic             rw_q;
  logic [7:0]       wdata_q;
  logic [7:0]       shreg_q;

  logic             tick;
  logic             bit_end;
  logic             sample;
  logic             last_bit;
  logic             accept;
  logic             in_byte;
  logic [7:0]       addr_byte;

  assign tick      = (cnt_q == CNT_MAX);
  assign bit_end   = tick && (qtr_q == 2'd3);
  assign sample    = tick && (qtr_q == 2'd2);
  assign last_bit  = bit_end && (bit_q == 3'd0);
  assign accept    = cmd_valid_i && (state_q == S_IDLE);
  assign in_byte   = (state_q == S_ADDR) || (state_q == S_WDATA) || (state_q == S_RDATA);
  assign addr_byte = {addr_q, rw_q};
  assign scl_oe_o  = 1'b1;

  // Control state: FSM, quarter engine, ACK status and response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      qtr_q       <= 2'd0;
      bit_q       <= 3'd7;
      nack_q      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 8'h00;
      rsp_nack_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_o <= 1'b0;
      if (state_q == S_IDLE) begin
        cnt_q <= '0;
        qtr_q <= 2'd0;
        bit_q <= 3'd7;
      end else begin
        cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) qtr_q <= qtr_q + 2'd1;
        // bit index counts down and wraps back to 7 for the next byte
        if (bit_end && in_byte) bit_q <= bit_q - 3'd1;
      end
      if (accept) begin
        nack_q      <= 1'b0;
        rsp_nack_o  <= 1'b0;
        rsp_rdata_o <= 8'h00;
      end
      if (sample && ((state_q == S_ADDR_ACK) || (state_q == S_WDATA_ACK))) nack_q <= sda_i;
      if (bit_end && (state_q == S_STOP)) begin
        rsp_valid_o <= 1'b1;
        rsp_nack_o  <= nack_q;
        rsp_rdata_o <= (rw_q && !nack_q) ? shreg_q : 8'h00;
      end
    end
  end

  // Command payload and read shift register carry no reset
  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q  <= cmd_addr_i;
      rw_q    <= cmd_rw_i;
      wdata_q <= cmd_wdata_i;
    end
    if (sample && (state_q == S_RDATA)) shreg_q <= {shreg_q[6:0], sda_i};
  end

  // Next state and bus levels; SCL is low for q0-q1 and high for q2-q3 of every bit
  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    scl_o       = 1'b1;
    sda_o       = 1'b1;
    sda_oe_o    = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_d = S_START;
      end
      S_START: begin
        sda_o = ~qtr_q[1];
        if (bit_end) state_d = S_ADDR;
      end
      S_ADDR: begin
        scl_o = qtr_q[1];
        sda_o = addr_byte[bit_q];
        if (last_bit) state_d = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        scl_o    = qtr_q[1];
        sda_oe_o = 1'b0;
        if (bit_end) begin
          if (nack_q)    state_d = S_STOP;
          else if (rw_q) state_d = S_RDATA;
          else           state_d = S_WDATA;
        end
      end
      S_WDATA: begin
        scl_o = qtr_q[1];
        sda_o = wdata_q[bit_q];
        if (last_bit) state_d = S_WDATA_ACK;
      end
      S_WDATA_ACK: begin
        scl_o    = qtr_q[1];
        sda_oe_o = 1'b0;
        if (bit_end) state_d = S_STOP;
      end
      S_RDATA: begin
        scl_o    = qtr_q[1];
        sda_oe_o = 1'b0;
        if (last_bit) state_d = S_RDATA_ACK;
      end
      S_RDATA_ACK: begin
        // single-byte read: master always NACKs
        scl_o = qtr_q[1];
        sda_o = 1'b1;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        scl_o = qtr_q[1];
        sda_o = (qtr_q == 2'd3);
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_cmd_master.sv
// Bench for i2c_cmd_master: behavioural I2C slave on the bus, vector table plus
// random commands checked against a transaction-level model, and corner sequences.
module tb_i2c_cmd_master;

  localparam int unsigned CLK_DIV = 4;
  localparam logic [6:0]  DEV     = 7'h66;

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] rd;
    logic       exp_nack;
    logic [7:0] exp_rdata;
    int         exp_lat;
    int         exp_rises;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       scl_o, scl_oe, sda_o, sda_oe;
  logic       pull = 1'b0;
  logic       sda_line;

  assign sda_line = (sda_oe ? sda_o : 1'b1) & ~pull;

  always #5 clk = ~clk;

  i2c_cmd_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_rw_i(cmd_rw), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_nack_o(rsp_nack),
    .scl_o(scl_o), .scl_oe_o(scl_oe), .sda_o(sda_o), .sda_oe_o(sda_oe),
    .sda_i(sda_line)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Bus monitor and slave, sampled on the falling clock edge
  int         cyc = 0;
  int         start_cnt = 0, stop_cnt = 0, last_start_cyc = 0, last_stop_cyc = 0;
  int         scl_rises = 0, wr_cnt = 0, ack9_cnt = 0, bitn = 0, pos, byt;
  logic [7:0] wr_data = 8'h00, sh = 8'h00, addr_byte = 8'h00, slv_rd = 8'h00;
  logic       ack9 = 1'b0, active = 1'b0, scl_p = 1'b1, sda_p = 1'b1, scl_c, sda_c;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_ni) begin
      active = 1'b0;
      pull   = 1'b0;
      scl_p  = 1'b1;
      sda_p  = 1'b1;
    end else begin
      scl_c = scl_oe ? scl_o : 1'b1;
      sda_c = sda_line;
      if (scl_p && scl_c && sda_p && !sda_c) begin
        start_cnt++; last_start_cyc = cyc; active = 1'b1; bitn = 0; pull = 1'b0;
      end else if (scl_p && scl_c && !sda_p && sda_c) begin
        stop_cnt++; last_stop_cyc = cyc; active = 1'b0; pull = 1'b0;
      end else if (active && !scl_p && scl_c) begin
        scl_rises++;
        bitn++;
        pos = (bitn - 1) % 9;
        byt = (bitn - 1) / 9;
        if (pos < 8) sh = {sh[6:0], sda_c};
        if (pos == 7 && byt == 0) addr_byte = sh;
        if (pos == 7 && byt == 1 && !addr_byte[0] && addr_byte[7:1] == DEV) begin
          wr_cnt++; wr_data = sh;
        end
        if (pos == 8 && byt == 1 && addr_byte[0]) begin
          ack9_cnt++; ack9 = sda_c;
        end
      end else if (active && scl_p && !scl_c) begin
        pos  = bitn % 9;
        byt  = bitn / 9;
        pull = 1'b0;
        if (byt == 0 && pos == 8) pull = (addr_byte[7:1] == DEV);
        if (byt == 1 && addr_byte[7:1] == DEV) begin
          if (addr_byte[0]) begin
            if (pos < 8) pull = ~slv_rd[3'(7 - pos)];
          end else if (pos == 8) begin
            pull = 1'b1;
          end
        end
      end
      scl_p = scl_c;
      sda_p = sda_c;
    end
  end

  // Transaction-level expectation: one address byte, plus a data byte if the target answered
  function automatic vec_t model(input logic [6:0] addr, input logic rw,
                                 input logic [7:0] wd, input logic [7:0] rd);
    vec_t v;
    int   nbytes;
    v.addr      = addr;
    v.rw        = rw;
    v.wdata     = wd;
    v.rd        = rd;
    v.exp_nack  = (addr != DEV);
    nbytes      = v.exp_nack ? 1 : 2;
    v.exp_rdata = (!v.exp_nack && rw) ? rd : 8'h00;
    v.exp_lat   = 1 + int'(CLK_DIV) * 4 * (2 + 9 * nbytes);
    v.exp_rises = 9 * nbytes + 1;
    return v;
  endfunction

  task automatic wait_rsp(input int a, output int lat);
    for (int n = 0; n < 4000 && !rsp_valid; n++) @(negedge clk);
    lat = rsp_valid ? (cyc - a) : -1;
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int a, lat, s_start, s_stop, s_wr, s_ack9, s_rises;
    logic [7:0] rd_hold;
    logic       nk_hold;
    slv_rd  = v.rd;
    s_start = start_cnt; s_stop = stop_cnt; s_wr = wr_cnt; s_ack9 = ack9_cnt; s_rises = scl_rises;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_rw = v.rw; cmd_wdata = v.wdata;
    chk({nm, ".ready_idle"}, 32'(cmd_ready), 32'd1);
    a = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_addr = 7'($urandom); cmd_rw = 1'($urandom); cmd_wdata = 8'($urandom);
    @(negedge clk);
    chk({nm, ".ready_busy"}, 32'(cmd_ready), 32'd0);
    wait_rsp(a, lat);
    chk({nm, ".latency"}, 32'(lat), 32'(v.exp_lat));
    chk({nm, ".nack"}, 32'(rsp_nack), 32'(v.exp_nack));
    chk({nm, ".rdata"}, 32'(rsp_rdata), 32'(v.exp_rdata));
    chk({nm, ".ready_rsp"}, 32'(cmd_ready), 32'd1);
    chk({nm, ".scl_rises"}, 32'(scl_rises - s_rises), 32'(v.exp_rises));
    chk({nm, ".starts"}, 32'(start_cnt - s_start), 32'd1);
    chk({nm, ".stops"}, 32'(stop_cnt - s_stop), 32'd1);
    chk({nm, ".slave_wr"}, 32'(wr_cnt - s_wr), 32'(!v.rw && !v.exp_nack));
    if (!v.rw && !v.exp_nack) chk({nm, ".slave_wdata"}, 32'(wr_data), 32'(v.wdata));
    if (v.rw && !v.exp_nack) begin
      chk({nm, ".ninth_seen"}, 32'(ack9_cnt - s_ack9), 32'd1);
      chk({nm, ".ninth_sda"}, 32'(ack9), 32'd1);
    end
    rd_hold = rsp_rdata;
    nk_hold = rsp_nack;
    @(negedge clk);
    chk({nm, ".pulse_len"}, 32'(rsp_valid), 32'd0);
    chk({nm, ".rdata_hold"}, 32'(rsp_rdata), 32'(rd_hold));
    chk({nm, ".nack_hold"}, 32'(rsp_nack), 32'(nk_hold));
  endtask

  initial begin
    vec_t vt[12];
    int   a, lat, s_start, s_stop, stop1;

    rst_ni = 1'b0; cmd_valid = 1'b0; cmd_addr = 7'h00; cmd_rw = 1'b0; cmd_wdata = 8'h00;

    vt[0] = '{7'h66, 1'b0, 8'hA5, 8'h00, 1'b0, 8'h00, 321, 19};
    vt[1] = '{7'h66, 1'b1, 8'h00, 8'h3C, 1'b0, 8'h3C, 321, 19};
    vt[2] = '{7'h12, 1'b0, 8'h5A, 8'h00, 1'b1, 8'h00, 177, 10};
    vt[3] = '{7'h12, 1'b1, 8'h00, 8'hC3, 1'b1, 8'h00, 177, 10};
    for (int i = 4; i < 12; i++)
      vt[i] = model(($urandom_range(0, 2) != 0) ? DEV : 7'($urandom), 1'($urandom),
                    8'($urandom), 8'($urandom));

    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(cmd_ready), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rdata", 32'(rsp_rdata), 32'h00);
    chk("rst.nack", 32'(rsp_nack), 32'd0);
    chk("rst.bus", 32'({scl_o, scl_oe, sda_o, sda_oe}), 32'hF);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle.bus", 32'({scl_o, scl_oe, sda_o, sda_oe}), 32'hF);

    for (int i = 0; i < 12; i++) run_txn(vt[i], $sformatf("vec%0d", i));

    // Back-to-back: valid stays high, second command taken on the response cycle
    slv_rd = 8'h5E; s_start = start_cnt; s_stop = stop_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = DEV; cmd_rw = 1'b0; cmd_wdata = 8'h11;
    a = cyc;
    @(posedge clk); #1;
    cmd_rw = 1'b1; cmd_wdata = 8'hEE;
    @(negedge clk);
    chk("b2b.busy", 32'(cmd_ready), 32'd0);
    wait_rsp(a, lat);
    chk("b2b.lat1", 32'(lat), 32'd321);
    chk("b2b.ready_rsp", 32'(cmd_ready), 32'd1);
    chk("b2b.wdata1", 32'(wr_data), 32'h11);
    chk("b2b.stops1", 32'(stop_cnt - s_stop), 32'd1);
    chk("b2b.starts1", 32'(start_cnt - s_start), 32'd1);
    stop1 = last_stop_cyc;
    a = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b.second_taken", 32'(cmd_ready), 32'd0);
    wait_rsp(a, lat);
    chk("b2b.lat2", 32'(lat), 32'd321);
    chk("b2b.rdata2", 32'(rsp_rdata), 32'h5E);
    chk("b2b.nack2", 32'(rsp_nack), 32'd0);
    chk("b2b.starts2", 32'(start_cnt - s_start), 32'd2);
    chk("b2b.stops2", 32'(stop_cnt - s_stop), 32'd2);
    chk("b2b.stop_before_start", 32'(last_start_cyc > stop1), 32'd1);

    // Reset pulse during the fourth read bit (q1, SCL low)
    slv_rd = 8'h96; s_start = start_cnt; s_stop = stop_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = DEV; cmd_rw = 1'b1; cmd_wdata = 8'h00;
    a = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int n = 0; n < 400 && cyc < a + 214; n++) @(negedge clk);
    chk("rstmid.pre_cycle", 32'(cyc - a), 32'd214);
    chk("rstmid.pre_bus", 32'({scl_o, sda_oe}), 32'd0);
    #2 rst_ni = 1'b0;
    #1;
    chk("rstmid.scl", 32'(scl_o), 32'd1);
    chk("rstmid.sda", 32'({sda_o, sda_oe}), 32'h3);
    chk("rstmid.ready", 32'(cmd_ready), 32'd1);
    chk("rstmid.rsp", 32'({rsp_valid, rsp_nack, rsp_rdata}), 32'h000);
    @(negedge clk);
    #2 rst_ni = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmid.starts", 32'(start_cnt - s_start), 32'd1);
    chk("rstmid.no_stop", 32'(stop_cnt - s_stop), 32'd0);
    run_txn(model(DEV, 1'b0, 8'($urandom), 8'h00), "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
